// File: rtl/sr_bank_driver.sv
// sr_bank_driver: set/reset pulse driver for a bank of SR flip-flops
// with readback verification and bounded retry.
module sr_bank_driver #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic [3:0]       r_cnt;
  logic [2:0]       r_retry;
  logic             r_done;
  logic             r_err;
  logic             w_done;
  logic             w_err;
  logic             w_accept;
  logic             w_match;
  logic             w_settled;
  logic             w_retry_left;

  assign w_accept     = in_valid && (r_state == IDLE);
  // X/Z on any readback bit counts as a mismatch
  assign w_match      = (q_fb === r_tgt);
  assign w_settled    = (r_cnt == 4'(SETTLE_CYC - 1));
  assign w_retry_left = (r_retry != 3'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == IDLE):   if (w_accept) w_next = DRIVE;
      (r_state == DRIVE):  w_next = SETTLE;
      (r_state == SETTLE): if (w_settled) w_next = CHECK;
      default:
        w_next = (!w_match && w_retry_left) ? DRIVE : IDLE;
    endcase
  end

  always_comb begin
    w_s    = '0;
    w_r    = '0;
    w_done = 1'b0;
    w_err  = 1'b0;
    if (r_state == DRIVE) begin
      // retries force every bit to recover cells left invalid
      if (r_retry == 3'd0) begin
        w_s = r_tgt & ~q_fb;
        w_r = ~r_tgt & q_fb;
      end else begin
        w_s = r_tgt;
        w_r = ~r_tgt;
      end
    end
    if (r_state == CHECK) begin
      w_done = w_match;
      w_err  = !w_match && !w_retry_left;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_s    <= w_s;
      r_r    <= w_r;
      r_done <= w_done;
      r_err  <= w_err;
      if (w_accept) r_tgt <= in_target;
      if (r_state == SETTLE && !w_settled) r_cnt <= r_cnt + 4'd1;
      else                                 r_cnt <= 4'd0;
      if (w_accept)
        r_retry <= 3'd0;
      else if (r_state == CHECK && !w_match && w_retry_left)
        r_retry <= r_retry + 3'd1;
    end
  end

  assign s        = r_s;
  assign r        = r_r;
  assign done     = r_done;
  assign err      = r_err;
  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_sr_bank_driver.sv
// tb_sr_bank_driver: directed vectors against a behavioural SR bank
// with stuck-output and invalid-bit injection.
module tb_sr_bank_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_target;
  logic [7:0] s;
  logic [7:0] r;
  logic [7:0] q_fb;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] bank_q;
  logic       bank_x;
  logic       bank_load;
  logic [7:0] bank_ld_val;
  logic       bank_ld_x;
  logic       stuck;
  logic [7:0] stuck_val;

  int errors = 0;
  int checks = 0;

  sr_bank_driver #(
    .WIDTH(8), .SETTLE_CYC(1), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target),
    .s(s), .r(r), .q_fb(q_fb),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // An invalid bit0 only recovers under a full-width drive.
  function automatic logic [7:0] bank_next(
    input logic [7:0] q, input logic [7:0] sv,
    input logic [7:0] rv, input logic x);
    logic [7:0] nq;
    nq = (q & ~rv) | sv;
    if (x && ((sv | rv) != 8'hFF)) nq[0] = q[0];
    return nq;
  endfunction

  always @(posedge clk) begin
    if (bank_load) begin
      bank_q <= bank_ld_val;
      bank_x <= bank_ld_x;
    end else begin
      bank_q <= bank_next(bank_q, s, r, bank_x);
      bank_x <= bank_x && ((s | r) != 8'hFF);
    end
  end

  assign q_fb = stuck  ? stuck_val :
                bank_x ? (bank_q & 8'hFE) : bank_q;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if ((s & r) != 8'h00 || (done && err)) begin
      errors++;
      $display("FAIL invariant: s=%h r=%h done=%b err=%b",
               s, r, done, err);
    end
  endtask

  task automatic set_bank(input logic [7:0] v, input logic x);
    bank_load   = 1'b1;
    bank_ld_val = v;
    bank_ld_x   = x;
    tick();
    bank_load   = 1'b0;
  endtask

  // Accept edge is k=1; pulses at k=2 and k=5; stop at done/err.
  task automatic run_op(input logic [7:0] tgt,
                        output int lat,
                        output logic [7:0] s1, output logic [7:0] r1,
                        output logic [7:0] s2, output logic [7:0] r2,
                        output int np,
                        output logic got_done, output logic got_err);
    lat = 41; s1 = 0; r1 = 0; s2 = 0; r2 = 0; np = 0;
    got_done = 0; got_err = 0;
    in_valid  = 1'b1;
    in_target = tgt;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        in_valid  = 1'b0;
        in_target = ~tgt;
      end
      if (k == 2) begin s1 = s; r1 = r; end
      if (k == 5) begin s2 = s; r2 = r; end
      if ((s | r) != 8'h00) np++;
      if (done || err) begin
        lat = k; got_done = done; got_err = err;
        break;
      end
    end
    tick();
    chk("one_cycle_pulse", {30'd0, done, err}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] q0;
    logic       x;
    logic       st;
    logic [7:0] tgt;
    logic [7:0] s1, r1, s2, r2;
    int         np;
    logic       dn, er;
    int         lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    int lat, np;
    logic [7:0] s1, r1, s2, r2;
    logic gd, ge;

    vt[0] = '{8'h00, 0, 0, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 1, 1, 0, 4};
    vt[1] = '{8'hF0, 0, 0, 8'h3C, 8'h0C, 8'hC0, 8'h00, 8'h00, 1, 1, 0, 4};
    vt[2] = '{8'h5A, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 4};
    vt[3] = '{8'hFF, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 4};
    vt[4] = '{8'h00, 0, 1, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE, 3, 0, 1, 10};
    vt[5] = '{8'h00, 1, 0, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE, 2, 1, 0, 7};

    rst = 1'b0; in_valid = 1'b0; in_target = 8'h00;
    bank_load = 1'b0; bank_ld_val = 8'h00; bank_ld_x = 1'b0;
    stuck = 1'b0; stuck_val = 8'h00;
    #12;
    chk("rst_s", {24'd0, s}, 32'h00);
    chk("rst_r", {24'd0, r}, 32'h00);
    chk("rst_flags", {28'd0, busy, done, err, in_ready}, 32'h1);
    set_bank(8'h00, 1'b0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      set_bank(vt[i].q0, vt[i].x);
      stuck     = vt[i].st;
      stuck_val = 8'h00;
      run_op(vt[i].tgt, lat, s1, r1, s2, r2, np, gd, ge);
      chk($sformatf("v%0d_s1", i), {24'd0, s1}, {24'd0, vt[i].s1});
      chk($sformatf("v%0d_r1", i), {24'd0, r1}, {24'd0, vt[i].r1});
      chk($sformatf("v%0d_s2", i), {24'd0, s2}, {24'd0, vt[i].s2});
      chk($sformatf("v%0d_r2", i), {24'd0, r2}, {24'd0, vt[i].r2});
      chk($sformatf("v%0d_np", i), np, vt[i].np);
      chk($sformatf("v%0d_done", i), {31'd0, gd}, {31'd0, vt[i].dn});
      chk($sformatf("v%0d_err", i), {31'd0, ge}, {31'd0, vt[i].er});
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      stuck = 1'b0;
    end

    // back-to-back with in_valid held high, in_target churned while busy
    set_bank(8'h00, 1'b0);
    in_valid  = 1'b1;
    in_target = 8'h11;
    lat = 41;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 2) chk("b2b_s1", {24'd0, s}, 32'h11);
      if (done) begin lat = k; break; end
      in_target = 8'hFF;
    end
    chk("b2b_lat1", lat, 4);
    chk("b2b_bank1", {24'd0, bank_q}, 32'h11);
    chk("b2b_ready_at_done", {31'd0, in_ready}, 32'd1);
    in_target = 8'h22;
    tick();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b2b_s2", {24'd0, s}, 32'h22);
    chk("b2b_r2", {24'd0, r}, 32'h11);
    lat = 41;
    for (int k = 3; k <= 40; k++) begin
      tick();
      if (done || err) begin lat = k; break; end
    end
    chk("b2b_lat2", lat, 4);
    chk("b2b_bank2", {24'd0, bank_q}, 32'h22);
    tick();

    // async reset while the first pulse is on the bus
    set_bank(8'h00, 1'b0);
    in_valid  = 1'b1;
    in_target = 8'h0F;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_s", {24'd0, s}, 32'h0F);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_s", {24'd0, s}, 32'h00);
    chk("abort_r", {24'd0, r}, 32'h00);
    chk("abort_flags", {28'd0, busy, done, err, in_ready}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_idle", {30'd0, busy, in_ready}, 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
